spi_tx_shifter: RTL and testbench
=================================

# spi_tx_shifter

SPI master transmit stage that drains the 8-bit byte FIFO and serialises each byte onto the SPI bus in mode 0 (CPOL=0, CPHA=0), MSB first. It sits directly downstream of the FIFO. It issues one-cycle read strobes, captures the FIFO output word, and drives SCLK, MOSI and CS_N. Consecutive bytes are sent as one continuous CS_N-low burst while the FIFO stays non-empty and the block stays enabled.

## Interface
- DATA_W, 8, byte width; must match the FIFO data width.
- CLK_DIV, 4, clk cycles per SCLK half-period; legal range is 1 and up.
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- enable  input  1  allows new bytes to be fetched.
- fifo_empty  input  1  FIFO has no data.
- fifo_data  input  DATA_W  FIFO read data; valid in the cycle after fifo_rd.
- fifo_rd  output  1  one-cycle FIFO read strobe.
- sclk  output  1  SPI clock; idles low.
- mosi  output  1  serial data, MSB first.
- cs_n  output  1  chip select, active low.
- busy  output  1  high in every state other than IDLE.
- done  output  1  one-cycle pulse when the last bit of a byte completes.

## Operation
- One clock domain; reset is synchronous and active-low. With rst_n=0 at a rising edge, the following edge shows: state=IDLE, cs_n=1, sclk=0, mosi=0, fifo_rd=0, busy=0, done=0, and all counters and the shift register at 0.
- States are IDLE, FETCH, LOAD and SHIFT.
- IDLE
  - Go to FETCH when enable=1 and fifo_empty=0.
  - Otherwise stay in IDLE with cs_n=1.
- FETCH (lasts 1 cycle)
  - fifo_rd=1; this is the only state that asserts fifo_rd.
  - Always go to LOAD.
- LOAD (lasts 1 cycle)
  - At the end of the cycle, fifo_data is captured into the shift register.
  - The bit counter is cleared to 0 and the divider counter to 0.
  - Go to SHIFT.
- SHIFT
  - cs_n=0. mosi equals shreg[DATA_W-1].
  - The divider counts 0..CLK_DIV-1, then wraps and toggles the phase. sclk equals the phase: the low half comes first, then the high half.
  - At each high-to-low phase transition the shift register shifts left by 1 and the bit counter increments. mosi therefore changes only while sclk is low, and it is stable across every sclk rising edge.
  - After the high half of bit DATA_W-1: done=1 for one cycle. If enable=1 and fifo_empty=0, go to FETCH; otherwise go to IDLE.
- In a back-to-back burst, cs_n stays 0 through FETCH and LOAD. sclk=0 and mosi holds its last value during the gap.
- Leaving SHIFT for IDLE: cs_n=1 on the same edge that done rises.
- enable falling mid-byte: the current byte completes in full; no further fifo_rd is issued; the block returns to IDLE.
- fifo_empty rising mid-byte: same as enable falling (byte completes, no further fifo_rd, return to IDLE).
- Reset mid-byte: abort immediately and apply the reset values on the next edge. The partial byte is lost and no fifo_rd is issued.
- fifo_rd is never asserted while fifo_empty=1 is sampled in the deciding cycle, so the FIFO never underflows.

## Timing
- Request to first SCLK low half:
  - request sampled in IDLE at edge k;
  - FETCH in cycle k+1;
  - LOAD in cycle k+2;
  - SHIFT starts at k+3, with cs_n falling at edge k+3.
- One bit lasts 2*CLK_DIV cycles; one byte occupies SHIFT for 2*CLK_DIV*DATA_W cycles (64 at the defaults).
- The inter-byte gap in a burst is 2 cycles with sclk low.
- Byte period in a burst: 2*CLK_DIV*DATA_W + 2 cycles.
- done and the final sclk falling edge occur on the same clk edge.
- The divider counter width is max(1, clog2(CLK_DIV)). The bit counter width is clog2(DATA_W)+1. Neither counter overflows: both are cleared in LOAD.

## Test plan
- Reset, then hold rst_n=0 for 3 cycles → cs_n=1, sclk=0, mosi=0, fifo_rd=0, busy=0, done=0 throughout.
- CLK_DIV=2; FIFO holds only 0xA5; enable=1 →
  - exactly one fifo_rd pulse;
  - mosi sampled on the 8 sclk rises reads 1,0,1,0,0,1,0,1;
  - cs_n low for 32 cycles;
  - one done pulse;
  - return to IDLE.
- FIFO preloaded with 02,04,08,16,32,64,6F,FF; enable=1 →
  - 8 fifo_rd pulses;
  - 64 sclk rises;
  - cs_n continuously low;
  - reconstructed bytes match in order;
  - 8 done pulses, with 2-cycle gaps between bytes.
- enable=1, fifo_empty=1 for 50 cycles → no fifo_rd, cs_n=1, sclk=0, busy=0.
- Two bytes queued, enable dropped after the 3rd sclk rise of byte 1 →
  - byte 1 completes with all 8 bits;
  - done pulses;
  - cs_n returns to 1;
  - no second fifo_rd.
- rst_n pulled low mid-byte at bit 4 →
  - next edge shows reset values;
  - no done pulse;
  - with enable=1 after release, a fresh FETCH begins for the next byte.

Source files
------------

// File: rtl/spi_tx_shifter.sv
// SPI mode-0 transmit stage: pops bytes from an upstream FIFO and shifts them out MSB first,
// keeping CS_N low across back-to-back bytes while data remains and the block stays enabled.
module spi_tx_shifter #(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned CLK_DIV = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_data,
   output logic              fifo_rd,
   output logic              sclk,
   output logic              mosi,
   output logic              cs_n,
   output logic              busy,
   output logic              done
);

   localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned CntW = $clog2(DATA_W) + 1;

   localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
   localparam logic [CntW-1:0] BitLast = CntW'(DATA_W - 1);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StFetch = 2'd1;
   localparam logic [1:0] StLoad  = 2'd2;
   localparam logic [1:0] StShift = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [DivW-1:0]   div_q, div_d;
   logic [CntW-1:0]   bit_q, bit_d;
   logic              phase_q, phase_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic              mosi_q, mosi_d;
   logic              cs_n_q, cs_n_d;
   logic              done_q, done_d;
   logic              want_next;

   assign want_next = enable & ~fifo_empty;

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      bit_d   = bit_q;
      phase_d = phase_q;
      shreg_d = shreg_q;
      mosi_d  = mosi_q;
      cs_n_d  = cs_n_q;
      done_d  = 1'b0;
      case (state_q)
         StIdle: begin
            cs_n_d = 1'b1;
            if (want_next) begin
               state_d = StFetch;
            end
         end
         StFetch: begin
            state_d = StLoad;
         end
         StLoad: begin
            shreg_d = fifo_data;
            mosi_d  = fifo_data[DATA_W-1];
            bit_d   = '0;
            div_d   = '0;
            phase_d = 1'b0;
            cs_n_d  = 1'b0;
            state_d = StShift;
         end
         StShift: begin
            if (div_q == DivLast) begin
               div_d   = '0;
               phase_d = ~phase_q;
               if (phase_q) begin
                  bit_d   = bit_q + 1'b1;
                  shreg_d = shreg_q << 1;
                  if (bit_q == BitLast) begin
                     // mosi keeps the last bit through the inter-byte gap
                     done_d = 1'b1;
                     if (want_next) begin
                        state_d = StFetch;
                     end else begin
                        state_d = StIdle;
                        cs_n_d  = 1'b1;
                     end
                  end else begin
                     mosi_d = shreg_d[DATA_W-1];
                  end
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         div_q   <= '0;
         bit_q   <= '0;
         phase_q <= 1'b0;
         shreg_q <= '0;
         mosi_q  <= 1'b0;
         cs_n_q  <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         phase_q <= phase_d;
         shreg_q <= shreg_d;
         mosi_q  <= mosi_d;
         cs_n_q  <= cs_n_d;
         done_q  <= done_d;
      end
   end

   assign fifo_rd = (state_q == StFetch);
   assign busy    = (state_q != StIdle);
   assign sclk    = phase_q;
   assign mosi    = mosi_q;
   assign cs_n    = cs_n_q;
   assign done    = done_q;

endmodule

// File: tb/tb_spi_tx_shifter.sv
// Bench for spi_tx_shifter: a queue-backed FIFO feeds the DUT and captured SPI traffic is
// compared against bytes, bit orders and cycle counts derived from the SPI mode-0 framing rules.
module tb_spi_tx_shifter;

   localparam int unsigned DW = 8;
   localparam int unsigned CD = 2;
   localparam int BIT_CYC  = 2 * CD;
   localparam int BYTE_CYC = 2 * CD * DW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          enable = 1'b0;
   logic          fifo_empty = 1'b1;
   logic [DW-1:0] fifo_data = '0;
   logic          fifo_rd, sclk, mosi, cs_n, busy, done;

   int total = 0;
   int bad = 0;

   logic [DW-1:0] fq[$];
   int            underflow_cnt = 0;

   // capture results
   bit            cap_bits[$];
   int            done_at[$];
   int            rd_cnt, cs_low, cs_falls, rd_cyc, csfall_cyc, done_sync_bad;
   bit            timed_out;

   spi_tx_shifter #(
      .DATA_W  (DW),
      .CLK_DIV (CD)
   ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .fifo_empty (fifo_empty),
      .fifo_data  (fifo_data),
      .fifo_rd    (fifo_rd),
      .sclk       (sclk),
      .mosi       (mosi),
      .cs_n       (cs_n),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   // FIFO model: serviced mid-cycle so the read strobe is sampled away from the active edge
   always @(negedge clk) begin
      if (fifo_rd && rst_n) begin
         if (fq.size() == 0) underflow_cnt++;
         else fifo_data = fq.pop_front();
      end
      fifo_empty = (fq.size() == 0);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] cap_byte(input int idx);
      logic [DW-1:0] b = '0;
      for (int i = 0; i < DW; i++) b = {b[DW-2:0], cap_bits[idx*DW+i]};
      return b;
   endfunction

   task automatic capture(input int max_cyc, input int drop_after);
      bit   seen_busy = 1'b0;
      bit   fin = 1'b0;
      logic prev_sclk = sclk;
      logic prev_cs = cs_n;
      cap_bits.delete();
      done_at.delete();
      rd_cnt = 0; cs_low = 0; cs_falls = 0; rd_cyc = -1; csfall_cyc = -1; done_sync_bad = 0;
      for (int c = 0; c < max_cyc && !fin; c++) begin
         tick();
         if (fifo_rd) begin
            rd_cnt++;
            if (rd_cyc < 0) rd_cyc = c;
         end
         if (sclk && !prev_sclk) begin
            cap_bits.push_back(mosi);
            if (drop_after != 0 && cap_bits.size() == drop_after) enable = 1'b0;
         end
         if (!cs_n) cs_low++;
         if (!cs_n && prev_cs) begin
            cs_falls++;
            if (csfall_cyc < 0) csfall_cyc = c;
         end
         if (done) begin
            done_at.push_back(c);
            if (!(prev_sclk && !sclk)) done_sync_bad++;
         end
         if (busy) seen_busy = 1'b1;
         else if (seen_busy) fin = 1'b1;
         prev_sclk = sclk;
         prev_cs = cs_n;
      end
      timed_out = !fin;
   endtask

   // Sends exp through the DUT and checks bytes, framing and burst timing.
   task automatic send_and_check(input string name, input logic [DW-1:0] exp[$]);
      int n = exp.size();
      foreach (exp[i]) fq.push_back(exp[i]);
      tick();
      enable = 1'b1;
      capture(n * (BYTE_CYC + 2) + 40, 0);
      enable = 1'b0;
      total++;
      if (timed_out !== 1'b0) begin
         bad++; $display("FAIL %s timeout: busy never returned low", name);
      end
      total++;
      if (rd_cnt !== n) begin
         bad++; $display("FAIL %s rd_count: got %0d want %0d", name, rd_cnt, n);
      end
      total++;
      if (cap_bits.size() !== n * DW) begin
         bad++; $display("FAIL %s sclk_rises: got %0d want %0d", name, cap_bits.size(), n * DW);
      end else begin
         for (int i = 0; i < n; i++) begin
            total++;
            if (cap_byte(i) !== exp[i]) begin
               bad++; $display("FAIL %s byte%0d: got %02h want %02h", name, i, cap_byte(i), exp[i]);
            end
         end
      end
      total++;
      if (cs_low !== n * BYTE_CYC + 2 * (n - 1)) begin
         bad++; $display("FAIL %s cs_low_cycles: got %0d want %0d", name, cs_low,
                         n * BYTE_CYC + 2 * (n - 1));
      end
      total++;
      if (cs_falls !== 1) begin
         bad++; $display("FAIL %s cs_falls: got %0d want 1", name, cs_falls);
      end
      total++;
      if (csfall_cyc - rd_cyc !== 2) begin
         bad++; $display("FAIL %s rd_to_cs_latency: got %0d want 2", name, csfall_cyc - rd_cyc);
      end
      total++;
      if (done_at.size() !== n) begin
         bad++; $display("FAIL %s done_count: got %0d want %0d", name, done_at.size(), n);
      end else begin
         for (int i = 1; i < n; i++) begin
            total++;
            if (done_at[i] - done_at[i-1] !== BYTE_CYC + 2) begin
               bad++; $display("FAIL %s byte_period%0d: got %0d want %0d", name, i,
                               done_at[i] - done_at[i-1], BYTE_CYC + 2);
            end
         end
      end
      total++;
      if (done_sync_bad !== 0) begin
         bad++; $display("FAIL %s done_vs_sclk_fall: got %0d misaligned want 0", name, done_sync_bad);
      end
      total++;
      if ({busy, cs_n, sclk} !== 3'b010) begin
         bad++; $display("FAIL %s end_idle: got busy/cs_n/sclk=%b want 010", name, {busy, cs_n, sclk});
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if ({cs_n, sclk, mosi, fifo_rd, busy, done} !== 6'b100000) begin
            bad++; $display("FAIL reset cyc%0d: got cs_n,sclk,mosi,rd,busy,done=%b want 100000",
                            i, {cs_n, sclk, mosi, fifo_rd, busy, done});
         end
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single();
      logic [DW-1:0] exp[$];
      exp.push_back(8'hA5);
      send_and_check("single_a5", exp);
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] exp[$];
      exp = '{8'h02, 8'h04, 8'h08, 8'h16, 8'h32, 8'h64, 8'h6F, 8'hFF};
      send_and_check("burst8", exp);
   endtask

   task automatic test_random();
      for (int it = 0; it < 4; it++) begin
         logic [DW-1:0] exp[$];
         int n = $urandom_range(1, 4);
         for (int i = 0; i < n; i++) exp.push_back(DW'($urandom_range(0, 255)));
         send_and_check($sformatf("random%0d", it), exp);
      end
   endtask

   task automatic test_idle_empty();
      int viol = 0;
      enable = 1'b1;
      for (int i = 0; i < 50; i++) begin
         tick();
         if ({fifo_rd, cs_n, sclk, busy} !== 4'b0100) viol++;
      end
      enable = 1'b0;
      total++;
      if (viol !== 0) begin
         bad++; $display("FAIL idle_empty: got %0d violating cycles want 0", viol);
      end
   endtask

   task automatic test_enable_drop();
      logic [DW-1:0] b1 = DW'($urandom_range(0, 255));
      logic [DW-1:0] b2 = DW'($urandom_range(0, 255));
      fq.push_back(b1);
      fq.push_back(b2);
      tick();
      enable = 1'b1;
      capture(BYTE_CYC * 3, 3);
      enable = 1'b0;
      total++;
      if (timed_out !== 1'b0) begin
         bad++; $display("FAIL en_drop timeout: busy never returned low");
      end
      total++;
      if (rd_cnt !== 1) begin
         bad++; $display("FAIL en_drop rd_count: got %0d want 1", rd_cnt);
      end
      total++;
      if (cap_bits.size() !== DW) begin
         bad++; $display("FAIL en_drop bits: got %0d want %0d", cap_bits.size(), DW);
      end else begin
         total++;
         if (cap_byte(0) !== b1) begin
            bad++; $display("FAIL en_drop byte: got %02h want %02h", cap_byte(0), b1);
         end
      end
      total++;
      if (done_at.size() !== 1) begin
         bad++; $display("FAIL en_drop done_count: got %0d want 1", done_at.size());
      end
      total++;
      if (cs_n !== 1'b1 || fq.size() !== 1) begin
         bad++; $display("FAIL en_drop end: got cs_n=%b fifo_left=%0d want 1/1", cs_n, fq.size());
      end
      fq.delete();
      repeat (3) tick();
   endtask

   task automatic test_reset_mid_byte();
      logic [DW-1:0] b1 = DW'($urandom_range(0, 255));
      logic [DW-1:0] b2 = DW'($urandom_range(0, 255));
      logic prev_sclk;
      int   rises = 0;
      int   done_seen = 0;
      fq.push_back(b1);
      fq.push_back(b2);
      tick();
      enable = 1'b1;
      prev_sclk = sclk;
      for (int c = 0; c < BYTE_CYC * 2 && rises < 4; c++) begin
         tick();
         if (sclk && !prev_sclk) rises++;
         if (done) done_seen++;
         prev_sclk = sclk;
      end
      total++;
      if (rises !== 4) begin
         bad++; $display("FAIL rst_mid reach_bit4: got %0d rises want 4", rises);
      end
      rst_n = 1'b0;
      tick();
      if (done) done_seen++;
      total++;
      if ({cs_n, sclk, mosi, fifo_rd, busy, done} !== 6'b100000) begin
         bad++; $display("FAIL rst_mid values: got cs_n,sclk,mosi,rd,busy,done=%b want 100000",
                         {cs_n, sclk, mosi, fifo_rd, busy, done});
      end
      total++;
      if (done_seen !== 0) begin
         bad++; $display("FAIL rst_mid no_done: got %0d done pulses want 0", done_seen);
      end
      rst_n = 1'b1;
      capture(BYTE_CYC * 3, 0);
      enable = 1'b0;
      total++;
      if (rd_cnt !== 1 || timed_out !== 1'b0) begin
         bad++; $display("FAIL rst_mid refetch: got rd=%0d timeout=%b want 1/0", rd_cnt, timed_out);
      end
      total++;
      if (cap_bits.size() !== DW) begin
         bad++; $display("FAIL rst_mid bits: got %0d want %0d", cap_bits.size(), DW);
      end else begin
         total++;
         if (cap_byte(0) !== b2) begin
            bad++; $display("FAIL rst_mid byte: got %02h want %02h", cap_byte(0), b2);
         end
      end
      repeat (3) tick();
   endtask

   task automatic test_no_underflow();
      total++;
      if (underflow_cnt !== 0) begin
         bad++; $display("FAIL underflow: got %0d reads while empty want 0", underflow_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_idle_empty();
      test_enable_drop();
      test_reset_mid_byte();
      test_random();
      test_no_underflow();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
